// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the RV32 front end.
package riscv_pkg;
   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; head is presented combinationally.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [2**AW];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage + IF/ID register with credit-limited imem requests and flush on redirect.
// Optional IF_PERF_CNT_EN adds the IF_BUBBLE_CNT bubble counter output.
module if_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH  = 2,
   parameter int unsigned MAX_OUTSTD = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        STALL_ID,
   input  logic        PCSrc_EX,
   input  logic [31:0] BRANCH_TARGET_EX,
   output logic [31:0] PC_ID,
   output logic [31:0] INSTRUCTION_ID,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] IF_BUBBLE_CNT,
`endif
   output logic        VALID_ID
);
   localparam int unsigned BCW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OCW = $clog2(MAX_OUTSTD + 1);

   fetch_entry_t    buf_head, rsp_entry, id_q, id_d;
   logic            valid_id_q, valid_id_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, tag_pc;
   logic [OCW-1:0]  drop_cnt_q, drop_cnt_d, outstanding;
   logic [BCW-1:0]  buf_count;
   logic            buf_push, buf_pop, buf_clear, buf_empty, buf_full;
   logic            tag_empty, tag_full;
   logic            req_fire, rsp_live, bubble_load;

   // Credit rule: outstanding requests always have a FIFO slot reserved.
   assign imem_req_valid = !reset && !PCSrc_EX && !tag_full &&
                           ((32'(buf_count) + 32'(outstanding)) < BUF_DEPTH);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_live       = imem_rsp_valid && (drop_cnt_q == '0);
   assign rsp_entry      = '{pc: tag_pc, instr: imem_rsp_data};

   fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(fetch_entry_t))) u_rsp_buf (
      .clk(clk), .reset(reset), .clear(buf_clear),
      .push(buf_push), .push_data(rsp_entry), .pop(buf_pop),
      .head(buf_head), .count(buf_count), .empty(buf_empty), .full(buf_full)
   );

   fetch_fifo #(.DEPTH(MAX_OUTSTD), .WIDTH(XLEN)) u_tag_q (
      .clk(clk), .reset(reset), .clear(1'b0),
      .push(req_fire), .push_data(fetch_pc_q), .pop(imem_rsp_valid),
      .head(tag_pc), .count(outstanding), .empty(tag_empty), .full(tag_full)
   );

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      drop_cnt_d  = drop_cnt_q;
      id_d        = id_q;
      valid_id_d  = valid_id_q;
      buf_push    = 1'b0;
      buf_pop     = 1'b0;
      buf_clear   = 1'b0;
      bubble_load = 1'b0;
      if (PCSrc_EX) begin
         fetch_pc_d = {BRANCH_TARGET_EX[XLEN-1:2], 2'b00};
         buf_clear  = 1'b1;
         valid_id_d = 1'b0;
         id_d.instr = NOP_INSTR;
         // Everything still in flight is stale, except a response consumed this cycle.
         drop_cnt_d = outstanding - OCW'(imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (imem_rsp_valid && !rsp_live) drop_cnt_d = drop_cnt_q - OCW'(1);
         if (STALL_ID) begin
            buf_push = rsp_live;
         end else if (!buf_empty) begin
            buf_pop    = 1'b1;
            buf_push   = rsp_live;
            id_d       = buf_head;
            valid_id_d = 1'b1;
         end else if (rsp_live) begin
            id_d       = rsp_entry;
            valid_id_d = 1'b1;
         end else begin
            valid_id_d  = 1'b0;
            id_d.instr  = NOP_INSTR;
            bubble_load = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         drop_cnt_q <= '0;
         id_q       <= '{pc: '0, instr: NOP_INSTR};
         valid_id_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_cnt_q <= drop_cnt_d;
         id_q       <= id_d;
         valid_id_q <= valid_id_d;
      end
   end

   assign PC_ID          = id_q.pc;
   assign INSTRUCTION_ID = id_q.instr;
   assign VALID_ID       = valid_id_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_load && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) bubble_cnt_q <= '0;
      else       bubble_cnt_q <= bubble_cnt_d;
   end

   assign IF_BUBBLE_CNT = bubble_cnt_q;
`else
   logic unused_bubble;
   assign unused_bubble = bubble_load;
`endif

   logic unused_bits;
   assign unused_bits = ^{tag_empty, buf_full, BRANCH_TARGET_EX[1:0]};
endmodule
